// File: rtl/ltssm_timer_ctrl.sv
// Per-state LTSSM timeout timer and TS1/TS2 run qualifier; counters restart on every state change.
// Optional `LTSSM_TIMER_FAST_SIM_EN: drops the prescaler so one "ms" equals one clk cycle.
module ltssm_timer_ctrl #(
  parameter int unsigned TICKS_PER_MS    = 250000,
  parameter int unsigned TS_COUNT_THRESH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ltssm_state,
  input  logic        ts1_rx_valid,
  input  logic        ts2_rx_valid,
  input  logic        ts_err,
  output logic        timeout,
  output logic        ts1_received,
  output logic        ts2_received,
  output logic [7:0]  timer_ms
);

  localparam int unsigned STATE_W = 11;
  localparam int unsigned MS_W    = 8;
  localparam int unsigned TS_W    = $clog2(TS_COUNT_THRESH + 1);

  logic [STATE_W-1:0] state_q;
  logic [TS_W-1:0]    ts1_cnt, ts2_cnt, ts1_cnt_d, ts2_cnt_d;
  logic [MS_W-1:0]    ms_d;
  logic [MS_W-1:0]    budget_c;
  logic               has_budget_c;
  logic               state_chg_c;
  logic               ms_tick_c;
  logic               expire_c;
  logic               timeout_d;

  assign state_chg_c = (ltssm_state != state_q);

  // Per-state budget in ms; states without a budget never time out.
  always_comb begin
    budget_c     = '0;
    has_budget_c = 1'b1;
    case (ltssm_state)
      11'd0:                budget_c = MS_W'(12);
      11'd2:                budget_c = MS_W'(24);
      11'd4:                budget_c = MS_W'(48);
      11'd5:                budget_c = MS_W'(24);
      11'd7:                budget_c = MS_W'(2);
      11'd9:                budget_c = MS_W'(2);
      11'd12:               budget_c = MS_W'(24);
      11'd14, 11'd15, 11'd16: budget_c = MS_W'(24);
      default:              has_budget_c = 1'b0;
    endcase
  end

`ifdef LTSSM_TIMER_FAST_SIM_EN
  assign ms_tick_c = 1'b1;
  // Look one cycle ahead so the registered timeout is high in cycle budget.
  assign expire_c  = has_budget_c && (timer_ms == budget_c - MS_W'(2));
`else
  localparam int unsigned PRE_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  logic [PRE_W-1:0] pre_q, pre_d;

  assign ms_tick_c = (pre_q == PRE_W'(TICKS_PER_MS - 1));
  // Fires on the last cycle before elapsed reaches budget*TICKS_PER_MS.
  assign expire_c  = has_budget_c && (timer_ms == budget_c - MS_W'(1)) &&
                     (pre_q == PRE_W'(TICKS_PER_MS - 2));

  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    if (state_chg_c || ms_tick_c) pre_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) pre_q <= '0;
    else        pre_q <= pre_d;
  end
`endif

  // Next-state for ms counter, sticky timeout and TS run counters; state change overrides all.
  always_comb begin
    ms_d      = timer_ms;
    timeout_d = timeout;
    ts1_cnt_d = ts1_cnt;
    ts2_cnt_d = ts2_cnt;
    if (state_chg_c) begin
      ms_d      = '0;
      timeout_d = 1'b0;
      ts1_cnt_d = '0;
      ts2_cnt_d = '0;
    end else begin
      if (ms_tick_c && (timer_ms != {MS_W{1'b1}})) ms_d = timer_ms + MS_W'(1);
      if (expire_c) timeout_d = 1'b1;
      if (ts_err) begin
        ts1_cnt_d = '0;
        ts2_cnt_d = '0;
      end else begin
        if (ts1_rx_valid && (ts1_cnt != TS_W'(TS_COUNT_THRESH))) ts1_cnt_d = ts1_cnt + TS_W'(1);
        if (ts2_rx_valid && (ts2_cnt != TS_W'(TS_COUNT_THRESH))) ts2_cnt_d = ts2_cnt + TS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= '0;
      timer_ms     <= '0;
      timeout      <= 1'b0;
      ts1_cnt      <= '0;
      ts2_cnt      <= '0;
      ts1_received <= 1'b0;
      ts2_received <= 1'b0;
    end else begin
      state_q      <= ltssm_state;
      timer_ms     <= ms_d;
      timeout      <= timeout_d;
      ts1_cnt      <= ts1_cnt_d;
      ts2_cnt      <= ts2_cnt_d;
      ts1_received <= (ts1_cnt_d == TS_W'(TS_COUNT_THRESH));
      ts2_received <= (ts2_cnt_d == TS_W'(TS_COUNT_THRESH));
    end
  end

endmodule

// File: tb/tb_ltssm_timer_ctrl.sv
// Directed bench for ltssm_timer_ctrl with TICKS_PER_MS=10; fast-sim checks when LTSSM_TIMER_FAST_SIM_EN is defined.
module tb_ltssm_timer_ctrl;

  logic        clk;
  logic        reset;
  logic [10:0] ltssm_state;
  logic        ts1_rx_valid;
  logic        ts2_rx_valid;
  logic        ts_err;
  logic        timeout;
  logic        ts1_received;
  logic        ts2_received;
  logic [7:0]  timer_ms;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic ts1;
    logic ts2;
    logic err;
    logic exp1;
    logic exp2;
  } vec_t;

  vec_t vecs[$];

  ltssm_timer_ctrl #(.TICKS_PER_MS(10), .TS_COUNT_THRESH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .ltssm_state  (ltssm_state),
    .ts1_rx_valid (ts1_rx_valid),
    .ts2_rx_valid (ts2_rx_valid),
    .ts_err       (ts_err),
    .timeout      (timeout),
    .ts1_received (ts1_received),
    .ts2_received (ts2_received),
    .timer_ms     (timer_ms)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset(input logic [10:0] st);
    reset        = 1'b0;
    ltssm_state  = st;
    ts1_rx_valid = 1'b0;
    ts2_rx_valid = 1'b0;
    ts_err       = 1'b0;
    repeat (3) step();
    reset = 1'b1;
  endtask

  function automatic vec_t mk(input logic a, input logic b, input logic e,
                              input logic x1, input logic x2);
    vec_t v;
    v.ts1 = a; v.ts2 = b; v.err = e; v.exp1 = x1; v.exp2 = x2;
    return v;
  endfunction

  initial begin
    reset = 1'b0; ltssm_state = '0;
    ts1_rx_valid = 1'b0; ts2_rx_valid = 1'b0; ts_err = 1'b0;

    // TS run table: ts1, ts2, err, expected ts1_received, expected ts2_received
    for (int i = 0; i < 7; i++) vecs.push_back(mk(1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0));

    // Reset state
    do_reset(11'd0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_ts1", int'(ts1_received), 0);
    check("rst_ts2", int'(ts2_received), 0);
    check("rst_timer_ms", int'(timer_ms), 0);

`ifdef LTSSM_TIMER_FAST_SIM_EN
    do_reset(11'd4);
    cyc = 0;
    while (cyc < 48) begin
      check("fast_early", int'(timeout), 0);
      step();
    end
    check("fast_expire", int'(timeout), 1);
    step();
    check("fast_ms49", int'(timer_ms), 48);
    check("fast_sticky", int'(timeout), 1);
`else
    // DETECT_QUIET budget, then a no-budget state
    cyc = 1;
    while (cyc < 120) begin
      check("dq_early", int'(timeout), 0);
      step();
    end
    check("dq_expire", int'(timeout), 1);
    check("dq_ms120", int'(timer_ms), 11);
    while (cyc < 130) step();
    check("dq_sticky", int'(timeout), 1);
    ltssm_state = 11'd1;
    step();
    check("s1_fall", int'(timeout), 0);
    check("s1_ms_clr", int'(timer_ms), 0);
    while (cyc < 1131) begin
      step();
      check("s1_none", int'(timeout), 0);
    end
    check("s1_ms", int'(timer_ms), 100);
    while (cyc < 2730) step();
    check("s1_ms_sat", int'(timer_ms), 255);
    check("s1_none_late", int'(timeout), 0);

    // State 7 left early, state 9 runs to its budget
    do_reset(11'd7);
    cyc = 0;
    while (cyc < 15) begin
      check("s7_none", int'(timeout), 0);
      step();
    end
    check("s7_none15", int'(timeout), 0);
    ltssm_state = 11'd9;
    step();
    while (cyc < 35) begin
      check("s9_early", int'(timeout), 0);
      step();
    end
    check("s9_expire", int'(timeout), 1);
    check("s9_ms", int'(timer_ms), 1);

    // TS run qualification from the table
    do_reset(11'd2);
    cyc = 0;
    step();
    foreach (vecs[i]) begin
      ts1_rx_valid = vecs[i].ts1;
      ts2_rx_valid = vecs[i].ts2;
      ts_err       = vecs[i].err;
      step();
      check($sformatf("ts1_rcv[%0d]", i), int'(ts1_received), int'(vecs[i].exp1));
      check($sformatf("ts2_rcv[%0d]", i), int'(ts2_received), int'(vecs[i].exp2));
    end
    ts2_rx_valid = 1'b0;
    ts_err       = 1'b0;
    ts1_rx_valid = 1'b1;
    repeat (7) step();
    check("ts1_requal", int'(ts1_received), 1);
    // State change coincident with a TS1 pulse: cleared, pulse not counted
    ltssm_state = 11'd4;
    step();
    check("chg_ts1_clr", int'(ts1_received), 0);
    check("chg_ts2_clr", int'(ts2_received), 0);
    repeat (7) step();
    check("chg_ts1_7", int'(ts1_received), 0);
    step();
    ts1_rx_valid = 1'b0;
    check("chg_ts1_8", int'(ts1_received), 1);

    // Reset mid-count in RECOVERY_RCVRLOCK
    do_reset(11'd12);
    cyc = 0;
    step();
    ts1_rx_valid = 1'b1;
    repeat (8) step();
    ts1_rx_valid = 1'b0;
    check("rl_ts1", int'(ts1_received), 1);
    while (cyc < 100) step();
    check("rl_ms100", int'(timer_ms), 9);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("rl_rst_timeout", int'(timeout), 0);
    check("rl_rst_ts1", int'(ts1_received), 0);
    check("rl_rst_ts2", int'(ts2_received), 0);
    check("rl_rst_ms", int'(timer_ms), 0);
    while (cyc < 341) begin
      check("rl_early", int'(timeout), 0);
      step();
    end
    check("rl_expire", int'(timeout), 1);
    check("rl_ms", int'(timer_ms), 23);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ltssm_timer_ctrl.md
# ltssm_timer_ctrl

Timer and ordered-set qualifier that sequences the PCIe LTSSM. It watches the LTSSM's 11-bit `state` output and produces the per-state `timeout` level that the LTSSM consumes. It also produces the `ts1_received` and `ts2_received` qualifiers, which assert only after a run of consecutive good training sets. The block sits between the PHY ordered-set decoder and the `ltssm` module and restarts all its counters on every LTSSM state change.

## Interface
- `TICKS_PER_MS`, 250000: clk cycles per millisecond (250 MHz).
- `TS_COUNT_THRESH`, 8: consecutive TS1/TS2 sets required to qualify.
- `clk`  in  1  clock.
- `reset`  in  1  reset.
  - Synchronous, active-low: `reset==0` at a `clk` rising edge resets the block.
- `ltssm_state`  in  11  LTSSM state encoding.
- `ts1_rx_valid`  in  1  one-cycle pulse per good TS1 decoded.
- `ts2_rx_valid`  in  1  one-cycle pulse per good TS2 decoded.
- `ts_err`  in  1  one-cycle pulse per malformed or unexpected ordered set.
- `timeout`  out  1  level; current state's budget has expired.
- `ts1_received`  out  1  level; TS1 run reached threshold.
- `ts2_received`  out  1  level; TS2 run reached threshold.
- `timer_ms`  out  8  debug; milliseconds elapsed in current state, saturating at 255.

## Operation
- State-code budgets, in ms:
  - 0 DETECT_QUIET: 12
  - 2 POLLING_ACTIVE: 24
  - 4 POLLING_CONFIGURATION: 48
  - 5 CONFIG_LINKWIDTH_START: 24
  - 7 CONFIG_LANENUM_WAIT: 2
  - 9 CONFIG_COMPLETE: 2
  - 12 RECOVERY_RCVRLOCK: 24
  - 14, 15, 16 RECOVERY_EQUALIZATION_PHASE_0..2: 24
  - All other codes: no budget. The timer still runs for `timer_ms`, but `timeout` never asserts.
- Registered copy `state_q`. A state change is detected when `ltssm_state != state_q`. That cycle is the entry cycle, cycle 0.
- On the entry cycle, all of the following clear at the closing edge:
  - prescaler
  - ms counter
  - `timeout`
  - both TS run counters
- Prescaler counts 0..`TICKS_PER_MS`-1 and emits `ms_tick` on wrap.
- ms counter increments on `ms_tick` and saturates at 255.
- `timeout` is a sticky register. It sets when the elapsed count reaches budget×`TICKS_PER_MS` and holds until the next state change or reset.
- TS run counters:
  - `ts1_rx_valid` increments `ts1_cnt`; `ts2_rx_valid` increments `ts2_cnt`.
  - Each counter saturates at `TS_COUNT_THRESH`.
  - A TS2 does not break a TS1 run, and vice versa.
  - `ts_err` clears both counters.
- `tsN_received` = (`tsN_cnt` == `TS_COUNT_THRESH`), registered.
- Simultaneous events:
  - `ts_err` with a valid pulse in the same cycle: the error wins and counters clear.
  - `ts1_rx_valid` and `ts2_rx_valid` together: both counters increment.
  - State change in the same cycle as a valid pulse or budget expiry: the state-change clear wins, and that pulse is not counted.

## Timing
- Reset values: all outputs 0; `state_q` = 0; all counters 0.
- First cycle after reset: `state_q` = 0, so no change is detected if `ltssm_state` = 0.
- `timeout` is observed high in cycle budget×`TICKS_PER_MS`, counting the entry cycle as cycle 0.
- `timeout` falls in cycle 1 of the next state.
- `tsN_received` rises the cycle after the threshold-reaching pulse.
- `tsN_received` falls the cycle after `ts_err` or a state change.
- `timer_ms` updates the cycle after `ms_tick`.
- Reset asserted mid-count: every counter and output is 0 in the cycle after the reset edge. Counting restarts from that point.

## Configuration
- `LTSSM_TIMER_FAST_SIM_EN`:
  - Defined: the prescaler is removed and `ms_tick` is asserted every cycle, so budgets count in clk cycles (DETECT_QUIET times out at cycle 12). `TICKS_PER_MS` is ignored.
  - Undefined: normal prescaled operation as above.

## Test plan
Bench uses `TICKS_PER_MS`=10 and the macro undefined unless stated.
- Reset with `reset`=0 for 3 cycles, inputs idle -> `timeout`, `ts1_received`, `ts2_received`, `timer_ms` all 0.
- Hold `ltssm_state`=0 -> `timeout` is 0 through cycle 119 and 1 at cycle 120. Switch to 1 at cycle 130 -> `timeout`=0 from cycle 131 and stays 0 for 1000 cycles.
- `ltssm_state`=7, switch to 9 at cycle 15 -> no `timeout` in state 7. In state 9, `timeout` rises 20 cycles after its entry cycle.
- `ltssm_state`=2: 7 `ts1_rx_valid` pulses, then `ts_err`, then 8 pulses -> `ts1_received` rises 1 cycle after the 8th post-error pulse. Then 8 `ts2_rx_valid` pulses, with two of them coincident with `ts1_rx_valid` -> `ts2_received`=1 and `ts1_received` still 1.
- `ltssm_state`=12; drive `reset`=0 for one edge at cycle 100, then release -> `timeout` rises at cycle 341 (240 cycles after restart), not at 240.
- `LTSSM_TIMER_FAST_SIM_EN` defined, `ltssm_state`=4 -> `timeout` rises at cycle 48 and `timer_ms` reads 48 at cycle 49.
